// File: rtl/pdm_cic_multich.sv
// NUM_CH-line PDM-to-PCM CIC decimator: parallel integrators, one shared comb stepping through channels.
// Latency: tick -> snapshot next cycle, channel k valid 2+k cycles after tick. Optional PDM_CIC_SAT_EN clamps output.
// Backpressure stalls the comb on its current channel; a tick during a stalled frame restarts it and sets sticky overrun.
module pdm_cic_multich #(
    parameter int NUM_CH = 2,
    parameter int ORDER  = 4,
    parameter int DECIM  = 64,
    parameter int OUT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    pdm_clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       pdm_data,
    output logic signed [OUT_W-1:0] dout,
    output logic [CH_W-1:0]         dout_ch,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    overrun
);
    localparam int LOG_D = $clog2(DECIM);
    localparam int ACC_W = ORDER * LOG_D + 1;
    localparam int SHIFT = ACC_W - OUT_W;
`ifdef PDM_CIC_SAT_EN
    // One guard bit keeps +full-scale distinct from -full-scale so the clamp can tell them apart.
    localparam int INT_W = ACC_W + 1;
    localparam logic signed [INT_W-1:0] SAT_HI = INT_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [INT_W-1:0] SAT_LO = INT_W'(-(2 ** (OUT_W - 1)));
`else
    localparam int INT_W = ACC_W;
`endif
    localparam logic signed [INT_W-1:0] STEP_P = INT_W'(1);
    localparam logic signed [INT_W-1:0] STEP_N = INT_W'(-1);

    typedef enum logic {IDLE, COMB} state_t;

    logic signed [INT_W-1:0] integ     [NUM_CH][ORDER];
    logic signed [INT_W-1:0] integ_nxt [NUM_CH][ORDER];
    logic signed [INT_W-1:0] snap      [NUM_CH];
    logic signed [INT_W-1:0] dly       [NUM_CH][ORDER];
    logic signed [INT_W-1:0] comb_in   [ORDER];
    logic signed [INT_W-1:0] comb_out;
    logic signed [OUT_W-1:0] sample;
    logic [LOG_D-1:0]        cnt;
    logic                    tick;
    state_t                  state, state_nxt;
    logic [CH_W-1:0]         ch, ch_nxt;
    logic                    load;
    logic                    overrun_nxt;

    assign tick = (cnt == LOG_D'(DECIM - 1));

    always_comb begin
        logic signed [INT_W-1:0] acc;
        for (int c = 0; c < NUM_CH; c++) begin
            acc = pdm_data[c] ? STEP_P : STEP_N;
            for (int s = 0; s < ORDER; s++) begin
                acc = integ[c][s] + acc;
                integ_nxt[c][s] = acc;
            end
        end
    end

    // Differential delay 1 in the decimated domain: each stage subtracts its previous input.
    always_comb begin
        logic signed [INT_W-1:0] v;
        v = snap[ch];
        for (int s = 0; s < ORDER; s++) begin
            comb_in[s] = v;
            v = v - dly[ch][s];
        end
        comb_out = v;
    end

`ifdef PDM_CIC_SAT_EN
    logic signed [INT_W-1:0] shifted;
    always_comb begin
        shifted = comb_out >>> SHIFT;
        if (shifted > SAT_HI)
            sample = SAT_HI[OUT_W-1:0];
        else if (shifted < SAT_LO)
            sample = SAT_LO[OUT_W-1:0];
        else
            sample = shifted[OUT_W-1:0];
    end
`else
    always_comb begin
        sample = OUT_W'(comb_out >>> SHIFT);
    end
`endif

    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        load        = 1'b0;
        overrun_nxt = overrun;
        if (state == COMB) begin
            load = !dout_valid || dout_ready;
            if (load) begin
                if (ch == CH_W'(NUM_CH - 1))
                    state_nxt = IDLE;
                else
                    ch_nxt = ch + 1'b1;
            end
        end
        // A new frame always wins; anything still pending from the old one is dropped.
        if (tick) begin
            if (state == COMB)
                overrun_nxt = 1'b1;
            state_nxt = COMB;
            ch_nxt    = '0;
        end
    end

    always_ff @(posedge pdm_clk) begin
        if (reset) begin
            cnt        <= '0;
            state      <= IDLE;
            ch         <= '0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                snap[c] <= '0;
                for (int s = 0; s < ORDER; s++) begin
                    integ[c][s] <= '0;
                    dly[c][s]   <= '0;
                end
            end
        end else begin
            cnt     <= cnt + 1'b1;
            state   <= state_nxt;
            ch      <= ch_nxt;
            overrun <= overrun_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < ORDER; s++)
                    integ[c][s] <= integ_nxt[c][s];
                if (tick)
                    snap[c] <= integ_nxt[c][ORDER-1];
            end
            if (load) begin
                dout       <= sample;
                dout_ch    <= ch;
                dout_valid <= 1'b1;
                for (int s = 0; s < ORDER; s++)
                    dly[ch][s] <= comb_in[s];
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pdm_cic_multich.sv
// Bench for pdm_cic_multich: expected PCM comes from convolving each PDM line with the CIC impulse response.
module tb_pdm_cic_multich;
    localparam int NUM_CH = 2;
    localparam int ORDER  = 4;
    localparam int DECIM  = 64;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = ORDER * $clog2(DECIM) + 1 - OUT_W;
    localparam int HLEN   = ORDER * (DECIM - 1) + 1;
    localparam int MAXC   = 2048;
    localparam logic signed [OUT_W-1:0] NEG_FS = 16'sh8000;
`ifdef PDM_CIC_SAT_EN
    localparam logic signed [OUT_W-1:0] POS_FS = 16'sh7fff;
`else
    localparam logic signed [OUT_W-1:0] POS_FS = 16'sh8000;
`endif

    logic                    pdm_clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_CH-1:0]       pdm_data = '0;
    logic signed [OUT_W-1:0] dout;
    logic [0:0]              dout_ch;
    logic                    dout_valid;
    logic                    dout_ready = 1'b1;
    logic                    overrun;

    typedef struct {
        int                      ch;
        int                      frame;
        logic signed [OUT_W-1:0] val;
    } exp_t;

    exp_t expq[$];
    int   h [HLEN];
    int   hist [NUM_CH][MAXC];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;

    always #5 pdm_clk = ~pdm_clk;

    pdm_cic_multich #(.NUM_CH(NUM_CH), .ORDER(ORDER), .DECIM(DECIM), .OUT_W(OUT_W)) u_dut (
        .pdm_clk(pdm_clk), .reset(reset), .pdm_data(pdm_data), .dout(dout),
        .dout_ch(dout_ch), .dout_valid(dout_valid), .dout_ready(dout_ready), .overrun(overrun)
    );

    // Impulse response of ORDER cascaded length-DECIM moving sums.
    function automatic void build_h();
        int tmp [HLEN];
        foreach (h[i]) h[i] = 0;
        h[0] = 1;
        for (int o = 0; o < ORDER; o++) begin
            for (int i = 0; i < HLEN; i++) begin
                tmp[i] = 0;
                for (int k = 0; k < DECIM && k <= i; k++) tmp[i] += h[i-k];
            end
            h = tmp;
        end
    endfunction

    function automatic int frame_val(int c, int m);
        int v = 0;
        for (int i = 0; i < HLEN; i++) begin
            int j = DECIM * m - i;
            if (j >= 1) v += h[i] * hist[c][j-1];
        end
        return v;
    endfunction

    function automatic logic signed [OUT_W-1:0] to_pcm(int v);
        int s = v >>> SHIFT;
`ifdef PDM_CIC_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s[OUT_W-1:0];
    endfunction

    function automatic logic [NUM_CH-1:0] rand_bits(int d0, int d1);
        logic [NUM_CH-1:0] b;
        b[0] = ($urandom_range(0, 99) < d0);
        b[1] = ($urandom_range(0, 99) < d1);
        return b;
    endfunction

    task automatic drive(input logic [NUM_CH-1:0] bits);
        cyc++;
        pdm_data = bits;
        if (cyc <= MAXC) begin
            for (int c = 0; c < NUM_CH; c++) hist[c][cyc-1] = bits[c] ? 1 : -1;
            if (cyc % DECIM == 0)
                for (int c = 0; c < NUM_CH; c++)
                    expq.push_back('{ch: c, frame: cyc / DECIM, val: to_pcm(frame_val(c, cyc / DECIM))});
        end
    endtask

    task automatic step(input logic [NUM_CH-1:0] bits);
        @(negedge pdm_clk);
        drive(bits);
    endtask

    // Leaves reset low at a negedge; the caller's next drive() is cycle 1.
    task automatic do_reset();
        reset = 1'b1;
        dout_ready = 1'b1;
        pdm_data = '0;
        repeat (3) @(negedge pdm_clk);
        reset = 1'b0;
        cyc = 0;
        expq.delete();
    endtask

    task automatic test_reset();
        int first = -1;
        reset = 1'b1;
        repeat (3) @(negedge pdm_clk);
        n_chk++;
        if (dout_valid !== 1'b0 || dout !== '0 || dout_ch !== 1'b0 || overrun !== 1'b0)
            $display("FAIL reset_state: valid=%b dout=%0d ch=%b ovr=%b, need 0/0/0/0",
                     dout_valid, dout, dout_ch, overrun);
        else n_pass++;
        do_reset();
        drive(rand_bits(50, 50));
        while (cyc < DECIM + 6) begin
            step(rand_bits(50, 50));
            if (dout_valid === 1'b1 && first < 0) first = cyc;
            if (cyc == DECIM + 3) begin
                n_chk++;
                if (dout_valid !== 1'b1 || dout_ch !== 1'b1)
                    $display("FAIL second_sample: valid=%b ch=%b, need 1/1", dout_valid, dout_ch);
                else n_pass++;
            end
        end
        n_chk++;
        if (first != DECIM + 2)
            $display("FAIL first_valid_cycle: got %0d, need %0d", first, DECIM + 2);
        else n_pass++;
    endtask

    task automatic test_random();
        int d0 = $urandom_range(5, 95);
        int d1 = $urandom_range(5, 95);
        logic prev_stall = 1'b0;
        logic signed [OUT_W-1:0] prev_dout = '0;
        logic [0:0] prev_ch = 1'b0;
        exp_t e;
        do_reset();
        drive(rand_bits(d0, d1));
        while (cyc < 12 * DECIM + 30) begin
            step(rand_bits(d0, d1));
            dout_ready = ($urandom_range(0, 3) != 0);
            if (prev_stall) begin
                n_chk++;
                if (dout_valid !== 1'b1 || dout !== prev_dout || dout_ch !== prev_ch)
                    $display("FAIL rand_hold: valid=%b dout=%0d ch=%b, need 1/%0d/%b",
                             dout_valid, dout, dout_ch, prev_dout, prev_ch);
                else n_pass++;
            end
            if (dout_valid === 1'b1 && dout_ready) begin
                n_chk++;
                if (expq.size() == 0) begin
                    $display("FAIL rand_extra: unexpected sample ch=%b dout=%0d", dout_ch, dout);
                end else begin
                    e = expq.pop_front();
                    if (dout !== e.val || dout_ch !== 1'(e.ch))
                        $display("FAIL rand_sample: frame %0d got ch=%b dout=%0d, need ch=%0d dout=%0d",
                                 e.frame, dout_ch, dout, e.ch, e.val);
                    else n_pass++;
                end
            end
            prev_stall = (dout_valid === 1'b1) && !dout_ready;
            prev_dout = dout;
            prev_ch = dout_ch;
        end
        dout_ready = 1'b1;
        n_chk++;
        if (expq.size() != 0 || overrun !== 1'b0)
            $display("FAIL rand_drain: pending=%0d ovr=%b, need 0/0", expq.size(), overrun);
        else n_pass++;
    endtask

    // ch0 held at 0, ch1 toggling 1010...
    task automatic test_patterns();
        exp_t e;
        logic signed [OUT_W-1:0] want;
        do_reset();
        for (int k = 0; k < 7 * DECIM + 8; k++) begin
            if (k == 0) drive({1'(k % 2), 1'b0});
            else step({1'(k % 2), 1'b0});
            if (dout_valid === 1'b1 && expq.size() > 0) begin
                e = expq.pop_front();
                n_chk++;
                if (dout !== e.val || dout_ch !== 1'(e.ch))
                    $display("FAIL pat_model: frame %0d got ch=%b dout=%0d, need ch=%0d dout=%0d",
                             e.frame, dout_ch, dout, e.ch, e.val);
                else n_pass++;
                if (e.frame >= ORDER + 1) begin
                    want = (e.ch == 0) ? NEG_FS : '0;
                    n_chk++;
                    if (dout !== want)
                        $display("FAIL pat_steady_ch%0d: got %0d, need %0d", e.ch, dout, want);
                    else n_pass++;
                end
            end
        end
    endtask

    // ch0 all ones, ch1 all zeros: full-scale pair every frame on adjacent cycles.
    task automatic test_full_scale();
        exp_t e;
        int last0 = -10;
        do_reset();
        drive(2'b01);
        while (cyc < 8 * DECIM + 8) begin
            step(2'b01);
            if (dout_valid === 1'b1 && expq.size() > 0) begin
                e = expq.pop_front();
                n_chk++;
                if (dout !== e.val || dout_ch !== 1'(e.ch))
                    $display("FAIL fs_model: frame %0d got ch=%b dout=%0d, need ch=%0d dout=%0d",
                             e.frame, dout_ch, dout, e.ch, e.val);
                else n_pass++;
                if (e.ch == 0) last0 = cyc;
                if (e.frame >= ORDER + 1) begin
                    n_chk++;
                    if (dout !== ((e.ch == 0) ? POS_FS : NEG_FS))
                        $display("FAIL fs_value_ch%0d: got %0d, need %0d", e.ch, dout,
                                 (e.ch == 0) ? POS_FS : NEG_FS);
                    else n_pass++;
                    if (e.ch == 1) begin
                        n_chk++;
                        if (last0 != cyc - 1)
                            $display("FAIL fs_adjacent: ch1 at cycle %0d, ch0 at %0d", cyc, last0);
                        else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [OUT_W-1:0] held = '0;
        logic signed [OUT_W-1:0] want;
        int seq [3];
        int nx = 0;
        do_reset();
        drive(2'b00);
        while (cyc < 4 * DECIM) begin
            step(2'b00);
            dout_ready = !(cyc >= 100 && cyc < 100 + 2 * DECIM);
            if (cyc == 2 * DECIM + 2) begin
                held = dout;
                want = to_pcm(frame_val(0, 2));
                n_chk++;
                if (dout_valid !== 1'b1 || dout_ch !== 1'b0 || dout !== want)
                    $display("FAIL bp_first: valid=%b ch=%b dout=%0d, need 1/0/%0d",
                             dout_valid, dout_ch, dout, want);
                else n_pass++;
            end
            if (cyc > 2 * DECIM + 2 && cyc < 100 + 2 * DECIM) begin
                n_chk++;
                if (dout_valid !== 1'b1 || dout_ch !== 1'b0 || dout !== held)
                    $display("FAIL bp_hold: cycle %0d valid=%b ch=%b dout=%0d, need 1/0/%0d",
                             cyc, dout_valid, dout_ch, dout, held);
                else n_pass++;
            end
            if (cyc == 3 * DECIM || cyc == 3 * DECIM + 1 || cyc == 3 * DECIM + 50) begin
                n_chk++;
                if (overrun !== (cyc > 3 * DECIM))
                    $display("FAIL bp_overrun: cycle %0d got %b, need %b", cyc, overrun, cyc > 3 * DECIM);
                else n_pass++;
            end
            if (dout_ready && dout_valid === 1'b1 && cyc >= 100 + 2 * DECIM && nx < 3) begin
                seq[nx] = int'(dout_ch);
                nx++;
            end
        end
        n_chk++;
        if (nx != 3 || seq[0] != 0 || seq[1] != 0 || seq[2] != 1)
            $display("FAIL bp_resume: %0d samples, ch seq %0d,%0d,%0d, need 0,0,1", nx, seq[0], seq[1], seq[2]);
        else n_pass++;
    endtask

    // Continues from the overrun state left by test_backpressure.
    task automatic test_reset_mid_comb();
        int first = -1;
        while (cyc < 5 * DECIM + 2) step(2'b00);
        n_chk++;
        if (dout_valid !== 1'b1 || dout_ch !== 1'b0 || overrun !== 1'b1)
            $display("FAIL midrst_pre: valid=%b ch=%b ovr=%b, need 1/0/1", dout_valid, dout_ch, overrun);
        else n_pass++;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(2'b00);
            n_chk++;
            if (dout_valid !== 1'b0 || overrun !== 1'b0 || dout !== '0)
                $display("FAIL midrst_clear: valid=%b ovr=%b dout=%0d, need 0/0/0", dout_valid, overrun, dout);
            else n_pass++;
        end
        reset = 1'b0;
        cyc = 0;
        expq.delete();
        drive(2'b00);
        while (cyc < DECIM + 4) begin
            step(2'b00);
            if (dout_valid === 1'b1 && first < 0) first = cyc;
        end
        n_chk++;
        if (first != DECIM + 2)
            $display("FAIL midrst_restart: first valid cycle %0d, need %0d", first, DECIM + 2);
        else n_pass++;
    endtask

    initial begin
        build_h();
        test_reset();
        test_random();
        test_patterns();
        test_full_scale();
        test_backpressure();
        test_reset_mid_comb();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pdm_cic_multich.md
Name: pdm_cic_multich

Overview:
- Parametrised successor to the single-channel CIC decimator at the front of the karaoke audio chain.
- Decimates NUM_CH independent 1-bit PDM microphone lines, all on one pdm_clk, to OUT_W-bit PCM.
- Integrators run in parallel per channel. The comb section is time-multiplexed, one channel per cycle.
- Results leave on a single valid/ready stream tagged with a channel index, feeding the halfband stages.

Parameters:
- NUM_CH, 2: number of PDM input lines, 1..8.
- ORDER, 4: CIC stages, 1..6.
- DECIM, 64: decimation ratio, power of two, must be ≥ NUM_CH+4.
- OUT_W, 16: output sample width.
- Derived localparams (not overridable):
  - ACC_W = ORDER*log2(DECIM)+1.
  - SHIFT = ACC_W-OUT_W.
  - CH_W = max(1,$clog2(NUM_CH)).

Ports:
- pdm_clk  in  1  PDM bit clock; only clock.
- reset  in  1  synchronous, active-high reset.
- pdm_data  in  NUM_CH  one PDM bit per channel per cycle.
- dout  out  OUT_W  signed two's-complement PCM sample.
- dout_ch  out  CH_W  channel index of dout.
- dout_valid  out  1  dout/dout_ch hold a sample.
- dout_ready  in  1  downstream accepts when valid&ready.
- overrun  out  1  sticky: a frame was abandoned.

Behaviour:
- Reset (sampled at the pdm_clk edge):
  - Clears all integrators, comb delays, snapshot, decimation counter, FSM → IDLE.
  - dout=0, dout_ch=0, dout_valid=0, overrun=0.
  - Reset mid-frame discards everything in flight.
- Input mapping: bit 1 → +1, bit 0 → −1, sign-extended to ACC_W.
- Integrators:
  - ORDER cascaded ACC_W-bit accumulators per channel, updated every cycle.
  - Modulo-2^ACC_W wrap is intended.
- Decimation counter:
  - Counts 0..DECIM-1. "tick" = counter==DECIM-1 (first tick DECIM cycles after reset release).
  - On tick: last-stage integrator values of all channels latch into the snapshot regs next cycle; FSM → COMB with ch=0.
- FSM:
  - IDLE: wait for tick.
  - COMB: per cycle, one channel's snapshot goes through ORDER combinational differentiators (differential delay 1) using that channel's comb delay regs.
    - Comb delay regs update only when the result is loaded into the output register.
    - Then ch++. After ch=NUM_CH-1 → IDLE.
  - Stall: COMB holds ch, with no delay update, while the output register is full and dout_ready=0.
- Scaling: comb result arithmetic >>> SHIFT, lower OUT_W bits taken (see optional feature).
- Output register:
  - Loads when empty or being consumed (dout_valid & dout_ready), so full throughput is 1 sample/cycle.
  - dout/dout_ch stay stable while dout_valid=1 & dout_ready=0.
- Latency, with ready held high:
  - Tick at cycle t → snapshot at t+1.
  - Channel k valid during cycle t+2+k.
- Overrun:
  - Trigger: a tick arrives while FSM in COMB (stalled).
  - Remaining channels of the old frame are dropped. overrun ← 1, held until reset.
  - The snapshot is replaced and the new frame restarts at ch=0.
  - The dropped channels' comb delays are not updated, so their next sample spans two periods. This glitch is accepted and not corrected.
  - A sample already in the output register is kept.
- Tick with FSM idle and output full: no overrun; snapshot proceeds normally.

Optional Feature:
- Macro: PDM_CIC_SAT_EN.
- Defined: a shifted result outside the signed OUT_W range clamps to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
- Undefined: plain truncation to the lower OUT_W bits (wrap).
- Note: with defaults, full-scale +1 gives +2^15, so the macro is required for positive full scale.

Test Plan:
- Reset and first sample:
  - Stimulus: defaults; release reset; dout_ready=1.
  - Response: first dout_valid exactly DECIM+2 cycles after release, dout_ch=0; next cycle dout_ch=1.
  - Stimulus: reset asserted 3 cycles mid-COMB.
  - Response: dout_valid=0 the cycle after; overrun=0.
- All-zero PDM:
  - Stimulus: ch0 all zeros.
  - Response: after ORDER+1 frames, dout=-32768 (0x8000) for ch0 every frame.
- Alternating 1010 PDM:
  - Stimulus: ch1 alternating 1010.
  - Response: steady-state ch1 dout=0.
- All-ones PDM:
  - Stimulus: all ones.
  - Response: with PDM_CIC_SAT_EN, dout=32767; without it, dout=-32768.
- Mixed channels:
  - Stimulus: ch0 ones, ch1 zeros (SAT_EN).
  - Response: pairs (ch0,32767),(ch1,-32768) on consecutive cycles each frame.
- Backpressure:
  - Stimulus: dout_ready=0 for 2*DECIM cycles.
  - Response: dout/dout_ch constant, dout_valid=1 throughout, overrun rises at the second tick and stays 1 after ready returns; stream resumes at ch=0.
